// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//    Run / pause / lap / clear controller for a stopwatch built from chained
//    decade counters. Turns debounced button levels into single-cycle presses,
//    sequences a four-state FSM, divides clk by PRESCALE to produce count
//    enables, clears the counter chain on request and flags overflow.
//
// Parameters
//    PRESCALE   clk cycles per count tick, 1 .. 2**PS_W
//    PS_W       prescaler register width
//    AUTO_STOP  1: overflow carry pauses the watch, 0: keep running and wrap
//
// Ports
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    btn_start  in   start/stop button level (debounced, synchronous)
//    btn_clear  in   clear button level (debounced, synchronous)
//    btn_lap    in   lap button level (debounced, synchronous)
//    carry_in   in   1-cycle carry from the most-significant decade stage
//    tick       out  1-cycle count enable to the least-significant stage
//    cnt_clr    out  1-cycle synchronous clear to the counter chain
//    disp_hold  out  1 while the display is frozen (LAP state)
//    state      out  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//    ovf        out  sticky overflow flag
// -----------------------------------------------------------------------------
module timer_ctrl #(
   parameter int PRESCALE  = 50000,
   parameter int PS_W      = 16,
   parameter bit AUTO_STOP = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_lap,
   input  logic       carry_in,
   output logic       tick,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [1:0] state,
   output logic       ovf
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   // Terminal prescaler count; PRESCALE may equal 2**PS_W, so PRESCALE-1 fits.
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [1:0]      state_q, state_d;
   logic [PS_W-1:0] ps_q, ps_d;
   logic            tick_q, tick_d;
   logic            clr_q, clr_d;
   logic            hold_q, hold_d;
   logic            ovf_q, ovf_d;
   logic            start_q, clear_q, lap_q;

   logic            press_start, press_clear, press_lap;
   logic            counting;
   logic [PS_W-1:0] ps_inc;

   // History registers reset to 1 so a button already held when reset
   // releases does not register as a press.
   assign press_start = btn_start & ~start_q;
   assign press_clear = btn_clear & ~clear_q;
   assign press_lap   = btn_lap   & ~lap_q;

   assign counting = (state_q == S_RUN) || (state_q == S_LAP);
   assign ps_inc   = (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      clr_d   = 1'b0;
      ovf_d   = ovf_q;

      // Within each state the highest-priority press that has a defined
      // action wins (clear > start > lap); presses with no action fall through.
      case (state_q)
         S_IDLE: begin
            ps_d = '0;
            if (press_clear) begin
               clr_d = 1'b1;
               ovf_d = 1'b0;
            end else if (press_start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            ps_d = ps_inc;
            if (press_start) begin
               state_d = S_PAUSE;
            end else if (press_lap) begin
               state_d = S_LAP;
            end
         end
         S_PAUSE: begin
            // ps frozen so the partial period resumes after restart
            if (press_clear) begin
               state_d = S_IDLE;
               ps_d    = '0;
               clr_d   = 1'b1;
               ovf_d   = 1'b0;
            end else if (press_start) begin
               state_d = S_RUN;
            end
         end
         default: begin // S_LAP
            ps_d = ps_inc;
            if (press_start) begin
               state_d = S_PAUSE;
            end else if (press_lap) begin
               state_d = S_RUN;
            end
         end
      endcase

      // Overflow overrides any button transition when auto-stop is enabled.
      if (counting && carry_in) begin
         ovf_d = 1'b1;
         if (AUTO_STOP) begin
            state_d = S_PAUSE;
         end
      end
   end

   // Decided from the current state, so a tick decided on the edge that
   // leaves RUN/LAP is still delivered in the following cycle.
   assign tick_d = counting && (ps_q == PS_MAX);
   assign hold_d = (state_d == S_LAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ps_q    <= '0;
         tick_q  <= 1'b0;
         clr_q   <= 1'b0;
         hold_q  <= 1'b0;
         ovf_q   <= 1'b0;
         start_q <= 1'b1;
         clear_q <= 1'b1;
         lap_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         tick_q  <= tick_d;
         clr_q   <= clr_d;
         hold_q  <= hold_d;
         ovf_q   <= ovf_d;
         start_q <= btn_start;
         clear_q <= btn_clear;
         lap_q   <= btn_lap;
      end
   end

   assign tick      = tick_q;
   assign cnt_clr   = clr_q;
   assign disp_hold = hold_q;
   assign state     = state_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//    Directed bench for timer_ctrl. Three instances share the button inputs:
//    dut0 PRESCALE=4 AUTO_STOP=1 (main checks), dut1 PRESCALE=4 AUTO_STOP=0
//    (wrap-on-overflow), dut2 PRESCALE=1 (continuous tick). Inputs change 1 ns
//    after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_start, btn_clear, btn_lap;
   logic       carry0, carry1;

   logic       tick0, clr0, hold0, ovf0;
   logic [1:0] state0;
   logic       tick1, clr1, hold1, ovf1;
   logic [1:0] state1;
   logic       tick2, clr2, hold2, ovf2;
   logic [1:0] state2;

   int n_tests = 0;
   int n_fail  = 0;
   int ticks;

   always #5 clk = ~clk;

   timer_ctrl #(.PRESCALE(4), .PS_W(16), .AUTO_STOP(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .carry_in(carry0), .tick(tick0), .cnt_clr(clr0),
      .disp_hold(hold0), .state(state0), .ovf(ovf0)
   );

   timer_ctrl #(.PRESCALE(4), .PS_W(16), .AUTO_STOP(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .carry_in(carry1), .tick(tick1), .cnt_clr(clr1),
      .disp_hold(hold1), .state(state1), .ovf(ovf1)
   );

   timer_ctrl #(.PRESCALE(1), .PS_W(4), .AUTO_STOP(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .carry_in(1'b0), .tick(tick2), .cnt_clr(clr2),
      .disp_hold(hold2), .state(state2), .ovf(ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_start = 1'b1;   // held through reset release
      btn_clear = 1'b0;
      btn_lap   = 1'b0;
      carry0    = 1'b0;
      carry1    = 1'b0;

      cyc(3);
      chk("rst_state", 32'(state0), 32'd0);
      chk("rst_tick",  32'(tick0),  32'd0);
      chk("rst_clr",   32'(clr0),   32'd0);
      chk("rst_hold",  32'(hold0),  32'd0);
      chk("rst_ovf",   32'(ovf0),   32'd0);

      rst_n = 1'b1;
      cyc(3);
      chk("held_btn_no_edge", 32'(state0), 32'd0);
      btn_start = 1'b0;
      cyc(1);

      // ---- 1: start, ticks every 4 cycles --------------------------------
      btn_start = 1'b1;
      cyc(1);                         // E0
      btn_start = 1'b0;
      chk("t1_state_run", 32'(state0), 32'd1);
      ticks = int'(tick0);
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         chk($sformatf("t1_tick_E0+%0d", k), 32'(tick0), 32'((k % 4) == 0));
         if (k <= 3) chk($sformatf("p1_tick_E0+%0d", k), 32'(tick2), 32'd1);
         ticks += int'(tick0);
      end
      chk("t1_tick_count", 32'(ticks), 32'd3);

      // ---- 2: pause keeps partial period ---------------------------------
      cyc(5);                         // E0+17
      btn_start = 1'b1;
      cyc(1);                         // E0+18, ps=2 frozen
      btn_start = 1'b0;
      chk("t2_state_pause", 32'(state0), 32'd2);
      ticks = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         ticks += int'(tick0);
      end
      chk("t2_no_ticks_paused", 32'(ticks), 32'd0);
      btn_start = 1'b1;
      cyc(1);                         // R
      btn_start = 1'b0;
      chk("t2_resume_state", 32'(state0), 32'd1);
      cyc(1);
      chk("t2_tick_R+1", 32'(tick0), 32'd0);
      cyc(1);
      chk("t2_tick_R+2", 32'(tick0), 32'd1);

      // ---- 3: lap / clear ignored while counting -------------------------
      btn_lap = 1'b1;
      cyc(1);                         // L, ps 0->1
      btn_lap = 1'b0;
      chk("t3_state_lap", 32'(state0), 32'd3);
      chk("t3_hold_on",   32'(hold0),  32'd1);
      btn_clear = 1'b1;
      cyc(1);                         // L+1, ps 2 (clear sampled here)
      btn_clear = 1'b0;
      chk("t3_lap_clr_ign", 32'(clr0),   32'd0);
      chk("t3_lap_state",   32'(state0), 32'd3);
      chk("t3_tick_L+1",    32'(tick0),  32'd0);
      cyc(1);                         // L+2, ps 3
      chk("t3_tick_L+2", 32'(tick0), 32'd0);
      cyc(1);                         // L+3, ps 0
      chk("t3_tick_L+3", 32'(tick0), 32'd1);
      chk("t3_hold_still", 32'(hold0), 32'd1);
      btn_lap = 1'b1;
      cyc(1);                         // L+4, ps 1
      btn_lap = 1'b0;
      chk("t3_state_run", 32'(state0), 32'd1);
      chk("t3_hold_off",  32'(hold0),  32'd0);
      btn_clear = 1'b1;
      cyc(1);                         // L+5, ps 2
      btn_clear = 1'b0;
      chk("t3_run_clr_ign", 32'(clr0),   32'd0);
      chk("t3_run_state",   32'(state0), 32'd1);
      btn_start = 1'b1;
      cyc(1);                         // L+6, ps 3 frozen in PAUSE
      btn_start = 1'b0;
      chk("t3_pause", 32'(state0), 32'd2);

      // ---- 4: simultaneous presses in PAUSE, clear wins ------------------
      btn_start = 1'b1;
      btn_clear = 1'b1;
      btn_lap   = 1'b1;
      cyc(1);
      chk("t4_state_idle", 32'(state0), 32'd0);
      chk("t4_clr_pulse",  32'(clr0),   32'd1);
      chk("t4_ovf",        32'(ovf0),   32'd0);
      chk("t4_hold",       32'(hold0),  32'd0);
      cyc(1);
      btn_start = 1'b0;
      btn_clear = 1'b0;
      btn_lap   = 1'b0;
      chk("t4_clr_one_cyc", 32'(clr0), 32'd0);
      cyc(1);
      btn_start = 1'b1;
      cyc(1);                         // S, ps cleared to 0
      btn_start = 1'b0;
      chk("t4_restart", 32'(state0), 32'd1);
      cyc(2);                         // S+2
      cyc(1);                         // S+3
      chk("t4_ps_cleared_S+3", 32'(tick0), 32'd0);
      btn_start = 1'b1;
      cyc(1);                         // S+4: tick decided while leaving RUN
      btn_start = 1'b0;
      chk("t4_tick_on_leave", 32'(tick0),  32'd1);
      chk("t4_leave_state",   32'(state0), 32'd2);
      cyc(1);                         // S+5
      chk("t4_tick_after", 32'(tick0), 32'd0);

      // ---- 5: overflow ----------------------------------------------------
      btn_start = 1'b1;
      cyc(1);                         // S+6 RUN, ps 0
      btn_start = 1'b0;
      btn_lap = 1'b1;
      cyc(1);                         // S+7 LAP, ps 1
      btn_lap = 1'b0;
      chk("t5_lap_hold", 32'(hold0), 32'd1);
      carry0 = 1'b1;
      carry1 = 1'b1;
      cyc(1);                         // S+8, ps 2
      carry0 = 1'b0;
      carry1 = 1'b0;
      chk("t5_as_state",  32'(state0), 32'd2);
      chk("t5_as_ovf",    32'(ovf0),   32'd1);
      chk("t5_as_hold",   32'(hold0),  32'd0);
      chk("t5_wrap_state", 32'(state1), 32'd3);
      chk("t5_wrap_ovf",   32'(ovf1),   32'd1);
      cyc(2);                         // S+10
      chk("t5_wrap_tick",   32'(tick1), 32'd1);
      chk("t5_as_no_tick",  32'(tick0), 32'd0);
      btn_start = 1'b1;
      cyc(1);                         // S+11 RUN
      btn_start = 1'b0;
      cyc(1);
      chk("t5_ovf_sticky_run", 32'(ovf0),   32'd1);
      chk("t5_run_again",      32'(state0), 32'd1);
      btn_start = 1'b1;
      cyc(1);                         // S+13 PAUSE
      btn_start = 1'b0;
      cyc(1);
      btn_clear = 1'b1;
      cyc(1);                         // S+15 IDLE
      btn_clear = 1'b0;
      chk("t5_clear_ovf",   32'(ovf0),   32'd0);
      chk("t5_clear_idle",  32'(state0), 32'd0);
      chk("t5_clear_pulse", 32'(clr0),   32'd1);
      carry0 = 1'b1;
      cyc(1);
      carry0 = 1'b0;
      chk("t5_idle_carry_ign", 32'(ovf0), 32'd0);

      // ---- 6: asynchronous reset with tick pending -----------------------
      btn_start = 1'b1;
      cyc(1);                         // T RUN, ps 0
      btn_start = 1'b0;
      cyc(3);                         // T+3, ps 3, tick pending
      rst_n = 1'b0;
      #1;
      chk("t6_async_state", 32'(state0), 32'd0);
      chk("t6_async_tick",  32'(tick0),  32'd0);
      #2;
      rst_n = 1'b1;
      ticks = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         ticks += int'(tick0) + int'(clr0);
      end
      chk("t6_no_pulse_after_rel", 32'(ticks),  32'd0);
      chk("t6_state_after_rel",    32'(state0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Run/pause/lap/clear controller for the stopwatch datapath built from chained decade counters. It converts button presses into a state machine and divides clk by a programmable prescaler. It drives the 1-cycle count-enable pulse into the least-significant decade stage and clears the chain. It watches the carry out of the most-significant stage for overflow and produces a display-freeze (lap) control.

Parameters:
PRESCALE, 50000, clk cycles per count tick; legal range 1..2^PS_W.
PS_W, 16, prescaler register width.
AUTO_STOP, 1, 1 = overflow carry forces PAUSE; 0 = keep running and wrap.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
btn_start  in  1  start/stop button, synchronous level, debounced upstream
btn_clear  in  1  clear button, synchronous level, debounced
btn_lap  in  1  lap button, synchronous level, debounced
carry_in  in  1  1-cycle carry pulse from the most-significant decade stage
tick  out  1  1-cycle count enable to the least-significant decade stage
cnt_clr  out  1  1-cycle synchronous clear pulse to the counter chain
disp_hold  out  1  level; 1 = display latches frozen (lap view)
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
ovf  out  1  sticky overflow flag

Behaviour:
- Reset values: state=IDLE, prescaler ps=0, tick=0, cnt_clr=0, disp_hold=0, ovf=0, button history registers=1.
  - History reset to 1 means a button already held at reset release gives no edge.
- Edge detect: press = btn & ~btn_q, with btn_q registered each clk.
  - A press acts on the first clk edge at which btn is sampled 1.
  - Holding a button gives exactly one press.
- Press priority when simultaneous: clear > start > lap.
- A press is ignored when the current state defines no action for it.
- IDLE:
  - ps held at 0; no ticks.
  - start -> RUN.
  - clear -> stays IDLE, pulses cnt_clr, clears ovf.
  - lap ignored.
- RUN:
  - ps increments each cycle, wrapping PRESCALE-1 -> 0.
  - start -> PAUSE.
  - lap -> LAP.
  - clear ignored.
- PAUSE:
  - ps frozen (keeps its value so the partial period resumes).
  - start -> RUN.
  - clear -> IDLE, ps=0, cnt_clr pulse, ovf=0.
  - lap ignored.
- LAP:
  - Counting continues exactly as in RUN; disp_hold=1 throughout LAP only.
  - lap -> RUN.
  - start -> PAUSE.
  - clear ignored.
- tick is registered: tick <= (state is RUN or LAP) && ps==PRESCALE-1.
  - First tick after entering RUN from IDLE is high in the cycle after the PRESCALE-th clk edge following the transition edge.
  - Thereafter exactly one tick every PRESCALE cycles.
  - PRESCALE=1: tick continuously high while counting; ps stays 0.
  - A tick decided on the edge that leaves RUN/LAP is still delivered (one cycle into PAUSE).
- cnt_clr: registered; high for exactly the one cycle after the edge accepting the clear press.
- Overflow: carry_in=1 while in RUN or LAP sets ovf=1.
  - AUTO_STOP=1: state -> PAUSE on the same edge and disp_hold releases.
  - AUTO_STOP=0: state unchanged, counting continues (chain wraps).
  - carry_in in IDLE/PAUSE is ignored.
  - carry_in coinciding with a start press in RUN: -> PAUSE and ovf=1.
- disp_hold is a registered function of state (1 iff next state is LAP), so it changes on the same edge as state.
- Asynchronous reset mid-operation returns everything to reset values immediately.
  - No tick or cnt_clr is emitted on reset release.

Test Plan:
1. PRESCALE=4: reset, press start at edge E0 -> state=01 after E0; tick high in the cycle after E0+4, E0+8, E0+12; exactly 3 ticks in 13 cycles.
2. Run 6 cycles, press start -> state=10, ps=2 retained, no ticks for 20 cycles; press start again -> next tick 2 edges after resume, not 4.
3. In RUN press lap -> state=11, disp_hold=1, ticks continue at period 4; press lap -> state=01, disp_hold=0; press clear during RUN/LAP -> no cnt_clr, state unchanged.
4. In PAUSE raise start, clear, lap on the same cycle -> clear wins: state=00, cnt_clr high exactly 1 cycle, ps=0, ovf=0.
5. AUTO_STOP=1: pulse carry_in in RUN -> state=10, ovf=1 sticky through start/RUN; clear from PAUSE -> ovf=0. With AUTO_STOP=0 -> ovf=1, state stays 01, ticks continue.
6. Hold btn_start high through reset release -> no transition; assert rst_n low mid-RUN with tick pending -> tick=0, state=00 immediately, no tick after release.
